// File: rtl/seq_scan_ctrl_if.sv
// Control, configuration, serial data and status bundle for seq_scan_ctrl.
interface seq_scan_ctrl_if #(
  parameter int PW = 4,
  parameter int CW = 4
);
  logic          start;
  logic          abort;
  logic [PW-1:0] cfg_pat;
  logic [2:0]    cfg_len;
  logic          cfg_ovl;
  logic [CW-1:0] cfg_max;
  logic          din;
  logic          din_vld;
  logic          busy;
  logic          done;
  logic          hit;
  logic [CW-1:0] cnt;
  logic [1:0]    st;

  modport master (
    output start, abort, cfg_pat, cfg_len, cfg_ovl, cfg_max, din, din_vld,
    input  busy, done, hit, cnt, st
  );

  modport slave (
    input  start, abort, cfg_pat, cfg_len, cfg_ovl, cfg_max, din, din_vld,
    output busy, done, hit, cnt, st
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Serial bit-pattern scanner: counts matches of a latched pattern in a din stream,
// with optional overlap, match-count stop and abort. State advances on falling ck.
module seq_scan_ctrl #(
  parameter int PW = 4,
  parameter int CW = 4
) (
  input logic            ck,
  input logic            rs,
  seq_scan_ctrl_if.slave bus
);

  localparam int LW = $clog2(PW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    SCAN = 2'b10,
    DONE = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovl_q, ovl_d;
  logic [CW-1:0] max_q, max_d;
  logic [PW-1:0] sr_q, sr_d;
  logic [LW-1:0] nb_q, nb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit_q, hit_d;
  logic          done_q, done_d;

  logic [31:0]   len_ext;
  logic [LW-1:0] eff_len;
  logic [PW-1:0] mask;
  logic [PW-1:0] sr_shift;
  logic [LW-1:0] nb_inc;
  logic [CW-1:0] cnt_inc;
  logic          match;

  // Out-of-range lengths (0 or wider than the shift register) fall back to PW.
  always_comb begin
    len_ext = {29'b0, bus.cfg_len};
    if (len_ext != 32'd0 && len_ext <= 32'(PW)) eff_len = LW'(len_ext);
    else                                        eff_len = LW'(PW);
  end

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PW; i++) mask[i] = (i < 32'(len_q));
  end

  assign sr_shift = {sr_q[PW-2:0], bus.din};
  assign nb_inc   = (nb_q == LW'(PW)) ? nb_q : nb_q + LW'(1);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  assign match    = (nb_inc >= len_q) && (((sr_shift ^ pat_q) & mask) == '0);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    max_d   = max_q;
    sr_d    = sr_q;
    nb_d    = nb_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: begin
        pat_d   = bus.cfg_pat;
        len_d   = eff_len;
        ovl_d   = bus.cfg_ovl;
        max_d   = bus.cfg_max;
        sr_d    = '0;
        nb_d    = '0;
        cnt_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        // Abort discards any bit presented on the same edge.
        if (bus.abort) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (bus.din_vld) begin
          sr_d = sr_shift;
          nb_d = (match && !ovl_q) ? '0 : nb_inc;
          if (match) begin
            hit_d = 1'b1;
            cnt_d = cnt_inc;
            if (max_q != '0 && cnt_inc == max_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge ck or posedge rs) begin
    if (rs) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      max_q   <= '0;
      sr_q    <= '0;
      nb_q    <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      max_q   <= max_d;
      sr_q    <= sr_d;
      nb_q    <= nb_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == LOAD) || (state_q == SCAN);
  assign bus.done = done_q;
  assign bus.hit  = hit_q;
  assign bus.cnt  = cnt_q;
  assign bus.st   = state_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl; outputs sampled 1 ns after each falling edge.
module tb_seq_scan_ctrl;

  logic ck = 1'b1;
  logic rs = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_scan_ctrl_if #(.PW(4), .CW(4)) bus ();

  seq_scan_ctrl #(.PW(4), .CW(4)) dut (
    .ck  (ck),
    .rs  (rs),
    .bus (bus.slave)
  );

  always #5 ck = ~ck;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge ck);
    #1;
  endtask

  // Runs IDLE->LOAD->SCAN, then scrambles the config inputs, which must be ignored.
  task automatic begin_scan(input logic [3:0] pat, input logic [2:0] len,
                            input logic ovl, input logic [3:0] max);
    bus.cfg_pat = pat;
    bus.cfg_len = len;
    bus.cfg_ovl = ovl;
    bus.cfg_max = max;
    bus.start   = 1'b1;
    step();
    check_eq("st_load", 32'(bus.st), 32'h1);
    check_eq("busy_load", 32'(bus.busy), 32'h1);
    bus.start = 1'b0;
    step();
    check_eq("st_scan", 32'(bus.st), 32'h2);
    check_eq("cnt_clr", 32'(bus.cnt), 32'h0);
    bus.cfg_pat = ~pat;
    bus.cfg_len = 3'd1;
    bus.cfg_ovl = ~ovl;
    bus.cfg_max = 4'd1;
  endtask

  task automatic run_stream(input string tag, input int n,
                            input logic [15:0] bits, input logic [15:0] exp_hits);
    for (int i = 0; i < n; i++) begin
      bus.din     = bits[i];
      bus.din_vld = 1'b1;
      step();
      bus.din_vld = 1'b0;
      check_eq($sformatf("%s_hit%0d", tag, i), 32'(bus.hit), 32'(exp_hits[i]));
    end
  endtask

  task automatic end_scan(input logic [3:0] exp_cnt);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_eq("abort_st", 32'(bus.st), 32'h3);
    check_eq("abort_done", 32'(bus.done), 32'h1);
    step();
    check_eq("idle_st", 32'(bus.st), 32'h0);
    check_eq("idle_done", 32'(bus.done), 32'h0);
    check_eq("idle_cnt", 32'(bus.cnt), 32'(exp_cnt));
  endtask

  initial begin
    logic [5:0] mx_bits, mx_hit, mx_done;
    logic [1:0] mx_st [6];
    int done_pulses;

    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_pat = '0; bus.cfg_len = '0;
    bus.cfg_ovl = 1'b0; bus.cfg_max = '0; bus.din = 1'b0; bus.din_vld = 1'b0;
    #1 rs = 1'b1;
    #10;
    check_eq("rst_st", 32'(bus.st), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_cnt", 32'(bus.cnt), 32'h0);
    check_eq("rst_hit", 32'(bus.hit), 32'h0);
    check_eq("rst_done", 32'(bus.done), 32'h0);
    rs = 1'b0;
    step();
    check_eq("idle_hold", 32'(bus.st), 32'h0);

    // Non-overlap: 0,1,1,0,1,1,0 against 0110
    begin_scan(4'b0110, 3'd4, 1'b0, 4'd0);
    run_stream("novl", 7, 16'b0110110, 16'b0001000);
    step();
    check_eq("gap_hit", 32'(bus.hit), 32'h0);
    check_eq("gap_cnt", 32'(bus.cnt), 32'h1);
    end_scan(4'd1);

    // Overlap: same stream
    begin_scan(4'b0110, 3'd4, 1'b1, 4'd0);
    run_stream("ovl", 7, 16'b0110110, 16'b1001000);
    check_eq("ovl_cnt", 32'(bus.cnt), 32'h2);
    end_scan(4'd2);

    // Max-stop: pat 01, len 2, max 2, stream 0,1,0,1,0,1
    begin_scan(4'b0001, 3'd2, 1'b0, 4'd2);
    mx_bits = 6'b101010;
    mx_hit  = 6'b001010;
    mx_done = 6'b001000;
    mx_st[0] = 2'b10; mx_st[1] = 2'b10; mx_st[2] = 2'b10;
    mx_st[3] = 2'b11; mx_st[4] = 2'b00; mx_st[5] = 2'b00;
    done_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      bus.din     = mx_bits[i];
      bus.din_vld = 1'b1;
      step();
      check_eq($sformatf("max_hit%0d", i), 32'(bus.hit), 32'(mx_hit[i]));
      check_eq($sformatf("max_done%0d", i), 32'(bus.done), 32'(mx_done[i]));
      check_eq($sformatf("max_st%0d", i), 32'(bus.st), 32'(mx_st[i]));
      if (bus.done) done_pulses++;
    end
    bus.din_vld = 1'b0;
    check_eq("max_cnt", 32'(bus.cnt), 32'h2);
    check_eq("max_done_pulses", 32'(done_pulses), 32'd1);

    // Abort on the completing bit of 0110
    begin_scan(4'b0110, 3'd4, 1'b0, 4'd0);
    run_stream("ab", 3, 16'b110, 16'b000);
    bus.din = 1'b0; bus.din_vld = 1'b1; bus.abort = 1'b1;
    step();
    bus.din_vld = 1'b0; bus.abort = 1'b0;
    check_eq("ab_hit", 32'(bus.hit), 32'h0);
    check_eq("ab_cnt", 32'(bus.cnt), 32'h0);
    check_eq("ab_st", 32'(bus.st), 32'h3);
    check_eq("ab_done", 32'(bus.done), 32'h1);
    step();
    check_eq("ab_done_off", 32'(bus.done), 32'h0);
    check_eq("ab_idle", 32'(bus.st), 32'h0);

    // cfg_len=0 acts as 4 with pat 1011; start during SCAN is ignored
    begin_scan(4'b1011, 3'd0, 1'b0, 4'd0);
    run_stream("len_a", 3, 16'b110, 16'b000);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_eq("len_start_st", 32'(bus.st), 32'h2);
    check_eq("len_start_cnt", 32'(bus.cnt), 32'h0);
    run_stream("len_b", 4, 16'b1101, 16'b1000);
    check_eq("len_cnt", 32'(bus.cnt), 32'h1);
    end_scan(4'd1);

    // Reset mid-SCAN with cnt=3
    begin_scan(4'b0001, 3'd1, 1'b0, 4'd0);
    run_stream("rs", 3, 16'b111, 16'b111);
    check_eq("rs_cnt3", 32'(bus.cnt), 32'h3);
    bus.din = 1'b1; bus.din_vld = 1'b1;
    #2 rs = 1'b1;
    #1;
    check_eq("rs_st", 32'(bus.st), 32'h0);
    check_eq("rs_cnt", 32'(bus.cnt), 32'h0);
    check_eq("rs_hit", 32'(bus.hit), 32'h0);
    check_eq("rs_busy", 32'(bus.busy), 32'h0);
    #2 rs = 1'b0;
    bus.din_vld = 1'b0;
    step();
    check_eq("rs_idle1", 32'(bus.st), 32'h0);
    step();
    check_eq("rs_idle2", 32'(bus.st), 32'h0);
    begin_scan(4'b0011, 3'd2, 1'b0, 4'd0);
    run_stream("rescan", 2, 16'b11, 16'b10);
    check_eq("rescan_cnt", 32'(bus.cnt), 32'h1);
    end_scan(4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
